// File: rtl/syn_gpu_pkg.sv
// Shared types for the GPU pixel gateway: HSI pixel format, frame defaults
// and the request word carried through the ingress FIFO.
package syn_gpu_pkg;

    localparam int PXL_W  = 8;
    localparam int ADDR_W = 19;
    localparam int FRM_W  = 640;
    localparam int FRM_H  = 480;

    // Packed hue/saturation/intensity pixel.
    typedef struct packed {
        logic [2:0] hue;
        logic [2:0] sat;
        logic [1:0] inten;
    } pxl_hsi_t;

    // One queued SRAM transaction: direction, linear address, write pixel.
    typedef struct packed {
        logic                  we;
        logic [ADDR_W-1:0]     addr;
        pxl_hsi_t              pxl;
    } pxl_gw_req_t;

endpackage

// File: rtl/syn_gpu_pxl_gw_if.sv
// Pixel-request and SRAM-controller signals of the pixel gateway.
// slave = gateway view, master = requester/controller view.
interface syn_gpu_pxl_gw_if #(
    parameter int P_X_W    = 10,
    parameter int P_Y_W    = 9,
    parameter int P_PXL_W  = 8,
    parameter int P_ADDR_W = 19
) ();

    logic                pxl_wr_valid;
    logic                pxl_rd_valid;
    logic [P_X_W-1:0]    posx;
    logic [P_Y_W-1:0]    posy;
    logic [P_PXL_W-1:0]  pxl;
    logic                ready;
    logic [P_PXL_W-1:0]  rd_pxl;
    logic                rd_pxl_valid;

    logic                sram_req;
    logic                sram_we;
    logic [P_ADDR_W-1:0] sram_addr;
    logic [P_PXL_W-1:0]  sram_wdata;
    logic                sram_ack;
    logic [P_PXL_W-1:0]  sram_rdata;
    logic                sram_rdata_vld;

    modport slave (
        input  pxl_wr_valid, pxl_rd_valid, posx, posy, pxl,
        input  sram_ack, sram_rdata, sram_rdata_vld,
        output ready, rd_pxl, rd_pxl_valid,
        output sram_req, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output pxl_wr_valid, pxl_rd_valid, posx, posy, pxl,
        output sram_ack, sram_rdata, sram_rdata_vld,
        input  ready, rd_pxl, rd_pxl_valid,
        input  sram_req, sram_we, sram_addr, sram_wdata
    );

endinterface

// File: rtl/syn_gpu_pxl_gw_fifo.sv
// Small synchronous first-word-fall-through FIFO of gateway requests.
// Head is read combinationally; the consumer registers it on pop.
module syn_gpu_pxl_gw_fifo
    import syn_gpu_pkg::*;
#(
    parameter int P_DEPTH = 4,
    localparam int PTR_W  = $clog2(P_DEPTH),
    localparam int CNT_W  = $clog2(P_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  pxl_gw_req_t      din,
    input  logic             pop,
    output pxl_gw_req_t      dout,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    pxl_gw_req_t      mem [P_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    // Guard both ends so a stray push on full / pop on empty cannot corrupt state.
    assign push_ok = push && (count_reg != CNT_W'(P_DEPTH));
    assign pop_ok  = pop && (count_reg != '0);

    assign dout  = mem[rd_ptr_reg];
    assign empty = (count_reg == '0);
    assign count = count_reg;

    // Storage array, written at the tail; no reset so it maps to RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/syn_gpu_pxl_gw.sv
// Pixel gateway: bounds-checks pixel requests, converts (x,y) to a linear
// frame-buffer address, queues them and issues them in order to the SRAM
// controller one at a time, returning read data to the requester.
module syn_gpu_pxl_gw
    import syn_gpu_pkg::*;
#(
    parameter int P_X_W    = 10,
    parameter int P_Y_W    = 9,
    parameter int P_FRM_W  = FRM_W,
    parameter int P_FRM_H  = FRM_H,
    parameter int P_PXL_W  = PXL_W,
    parameter int P_ADDR_W = ADDR_W,
    parameter int P_FIFO_D = 4
) (
    input  logic               clk_ir,
    input  logic               rst_sync,
    syn_gpu_pxl_gw_if.slave    bus,
    output logic [15:0]        drop_cnt
);

    localparam logic [1:0] IDLE_S    = 2'd0;
    localparam logic [1:0] ISSUE_S   = 2'd1;
    localparam logic [1:0] RD_WAIT_S = 2'd2;

    localparam int              CNT_W     = $clog2(P_FIFO_D + 1);
    localparam logic [P_X_W-1:0] FRM_W_X  = P_X_W'(P_FRM_W);
    localparam logic [P_Y_W-1:0] FRM_H_Y  = P_Y_W'(P_FRM_H);

    logic [1:0]          state_reg;
    pxl_gw_req_t         out_req_reg;
    logic                sram_req_reg;
    logic [P_PXL_W-1:0]  rd_pxl_reg;
    logic                rd_pxl_valid_reg;
    logic [15:0]         drop_cnt_reg;

    logic [P_ADDR_W-1:0] addr_calc;
    logic                in_valid;
    logic                on_screen;
    logic                push;
    logic                drop;
    logic                pop;
    logic                ready;
    pxl_gw_req_t         req_in;
    pxl_gw_req_t         fifo_head;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;

    // Linear address: the 640-wide frame avoids a multiplier (640 = 512 + 128).
    generate
        if (P_FRM_W == 640) begin : g_addr_shift
            assign addr_calc = (P_ADDR_W'(bus.posy) << 9) + (P_ADDR_W'(bus.posy) << 7)
                             + P_ADDR_W'(bus.posx);
        end else begin : g_addr_mult
            assign addr_calc = P_ADDR_W'(bus.posy) * P_ADDR_W'(P_FRM_W) + P_ADDR_W'(bus.posx);
        end
    endgenerate

    // A write wins if both valids are raised together.
    assign in_valid  = bus.pxl_wr_valid | bus.pxl_rd_valid;
    assign on_screen = (bus.posx < FRM_W_X) && (bus.posy < FRM_H_Y);
    assign ready     = (fifo_count != CNT_W'(P_FIFO_D));
    assign push      = in_valid && ready && on_screen;
    assign drop      = in_valid && ready && !on_screen;
    assign pop       = (state_reg == IDLE_S) && !fifo_empty;

    // Assemble the queued request word at ingress.
    always_comb begin
        req_in      = '0;
        req_in.we   = bus.pxl_wr_valid;
        req_in.addr = ADDR_W'(addr_calc);
        req_in.pxl  = pxl_hsi_t'(PXL_W'(bus.pxl));
    end

    syn_gpu_pxl_gw_fifo #(
        .P_DEPTH (P_FIFO_D)
    ) u_fifo (
        .clk   (clk_ir),
        .srst  (rst_sync),
        .push  (push),
        .din   (req_in),
        .pop   (pop),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Transaction FSM: pop, hold request until ack, then wait for read data.
    always_ff @(posedge clk_ir) begin
        if (rst_sync) begin
            state_reg        <= IDLE_S;
            out_req_reg      <= '0;
            sram_req_reg     <= 1'b0;
            rd_pxl_reg       <= '0;
            rd_pxl_valid_reg <= 1'b0;
        end else begin
            rd_pxl_valid_reg <= 1'b0;
            case (state_reg)
                IDLE_S: begin
                    if (!fifo_empty) begin
                        out_req_reg <= fifo_head;
                        state_reg   <= ISSUE_S;
                    end
                end
                ISSUE_S: begin
                    if (!sram_req_reg) begin
                        sram_req_reg <= 1'b1;
                    end else if (bus.sram_ack) begin
                        sram_req_reg <= 1'b0;
                        state_reg    <= out_req_reg.we ? IDLE_S : RD_WAIT_S;
                    end
                end
                RD_WAIT_S: begin
                    if (bus.sram_rdata_vld) begin
                        rd_pxl_reg       <= bus.sram_rdata;
                        rd_pxl_valid_reg <= 1'b1;
                        state_reg        <= IDLE_S;
                    end
                end
                default: state_reg <= IDLE_S;
            endcase
        end
    end

    // Saturating count of off-screen requests.
    always_ff @(posedge clk_ir) begin
        if (rst_sync) begin
            drop_cnt_reg <= '0;
        end else if (drop && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign bus.ready        = ready;
    assign bus.rd_pxl       = rd_pxl_reg;
    assign bus.rd_pxl_valid = rd_pxl_valid_reg;
    assign bus.sram_req     = sram_req_reg;
    assign bus.sram_we      = out_req_reg.we;
    assign bus.sram_addr    = P_ADDR_W'(out_req_reg.addr);
    assign bus.sram_wdata   = P_PXL_W'(out_req_reg.pxl);
    assign drop_cnt         = drop_cnt_reg;

endmodule

// File: tb/tb_syn_gpu_pxl_gw.sv
// Directed bench for the pixel gateway with hand-computed addresses/data.
module tb_syn_gpu_pxl_gw;

    logic        clk_ir;
    logic        rst_sync;
    logic [15:0] drop_cnt;
    int          n_chk;
    int          n_fail;

    syn_gpu_pxl_gw_if bus ();

    syn_gpu_pxl_gw dut (
        .clk_ir   (clk_ir),
        .rst_sync (rst_sync),
        .bus      (bus),
        .drop_cnt (drop_cnt)
    );

    initial clk_ir = 1'b0;
    always #5 clk_ir = ~clk_ir;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk_ir);
        #1;
    endtask

    task automatic push(input logic we, input int x, input int y, input logic [7:0] p);
        bus.pxl_wr_valid = we;
        bus.pxl_rd_valid = !we;
        bus.posx         = 10'(x);
        bus.posy         = 9'(y);
        bus.pxl          = p;
        tick();
        bus.pxl_wr_valid = 1'b0;
        bus.pxl_rd_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (bus.sram_req) break;
            tick();
        end
        chk(tag, 32'(bus.sram_req), 32'd1);
    endtask

    task automatic check_req(input string tag, input logic we, input int addr, input logic [7:0] wd);
        chk({tag, "_we"}, 32'(bus.sram_we), 32'(we));
        chk({tag, "_addr"}, 32'(bus.sram_addr), 32'(addr));
        if (we) chk({tag, "_wdata"}, 32'(bus.sram_wdata), 32'(wd));
    endtask

    task automatic do_ack(input string tag);
        bus.sram_ack = 1'b1;
        tick();
        bus.sram_ack = 1'b0;
        chk({tag, "_req_drop"}, 32'(bus.sram_req), 32'd0);
    endtask

    task automatic do_rdata(input string tag, input logic [7:0] d);
        tick();
        tick();
        chk({tag, "_no_early_rv"}, 32'(bus.rd_pxl_valid), 32'd0);
        bus.sram_rdata_vld = 1'b1;
        bus.sram_rdata     = d;
        tick();
        bus.sram_rdata_vld = 1'b0;
        chk({tag, "_rv"}, 32'(bus.rd_pxl_valid), 32'd1);
        chk({tag, "_rd_pxl"}, 32'(bus.rd_pxl), 32'(d));
        tick();
        chk({tag, "_rv_1cyc"}, 32'(bus.rd_pxl_valid), 32'd0);
    endtask

    initial begin
        n_chk              = 0;
        n_fail             = 0;
        rst_sync           = 1'b1;
        bus.pxl_wr_valid   = 1'b0;
        bus.pxl_rd_valid   = 1'b0;
        bus.posx           = '0;
        bus.posy           = '0;
        bus.pxl            = '0;
        bus.sram_ack       = 1'b0;
        bus.sram_rdata     = '0;
        bus.sram_rdata_vld = 1'b0;
        repeat (3) tick();
        rst_sync = 1'b0;

        // Reset state
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_req", 32'(bus.sram_req), 32'd0);
        chk("rst_addr", 32'(bus.sram_addr), 32'd0);
        chk("rst_rv", 32'(bus.rd_pxl_valid), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);

        // Write (3,2)=A5: addr 2*640+3 = 1283, req appears two edges after push
        push(1'b1, 3, 2, 8'hA5);
        chk("w1_lat0", 32'(bus.sram_req), 32'd0);
        tick();
        chk("w1_lat1", 32'(bus.sram_req), 32'd0);
        tick();
        chk("w1_lat2", 32'(bus.sram_req), 32'd1);
        check_req("w1", 1'b1, 1283, 8'hA5);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("w1_hold", 32'(bus.sram_req), 32'd1);
            chk("w1_no_rv", 32'(bus.rd_pxl_valid), 32'd0);
        end
        do_ack("w1");
        tick();
        chk("w1_no_rv_after", 32'(bus.rd_pxl_valid), 32'd0);

        // Read (639,479): addr 479*640+639 = 307199
        push(1'b0, 639, 479, 8'h00);
        wait_req("r1_req");
        check_req("r1", 1'b0, 307199, 8'h00);
        do_ack("r1");
        do_rdata("r1", 8'h3C);

        // Off-screen drops
        push(1'b1, 640, 0, 8'h55);
        chk("drop1_ready", 32'(bus.ready), 32'd1);
        push(1'b1, 0, 480, 8'h66);
        chk("drop2_ready", 32'(bus.ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drop_no_req", 32'(bus.sram_req), 32'd0);
        end
        chk("drop_cnt", 32'(drop_cnt), 32'd2);

        // Withheld ack: one issuing + four queued fills the FIFO
        push(1'b1, 10, 1, 8'h20);
        wait_req("fill_req0");
        for (int i = 1; i < 5; i++) begin
            chk("fill_ready_pre", 32'(bus.ready), 32'd1);
            push(1'b1, 10 + i, 1, 8'(8'h20 + i));
        end
        chk("fill_ready_full", 32'(bus.ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            wait_req("fill_req");
            check_req("fill", 1'b1, 650 + i, 8'(8'h20 + i));
            do_ack("fill");
        end
        chk("fill_ready_back", 32'(bus.ready), 32'd1);

        // Write then read same pixel back-to-back: addr 5*640+5 = 3205
        push(1'b1, 5, 5, 8'h11);
        push(1'b0, 5, 5, 8'h00);
        wait_req("raw_w_req");
        check_req("raw_w", 1'b1, 3205, 8'h11);
        do_ack("raw_w");
        wait_req("raw_r_req");
        check_req("raw_r", 1'b0, 3205, 8'h00);
        do_ack("raw_r");
        do_rdata("raw_r", 8'h11);

        // Reset while waiting for read data: aborted, late data ignored
        push(1'b0, 7, 7, 8'h00);
        wait_req("abort_req");
        check_req("abort", 1'b0, 4487, 8'h00);
        do_ack("abort");
        rst_sync = 1'b1;
        tick();
        rst_sync = 1'b0;
        chk("abort_req0", 32'(bus.sram_req), 32'd0);
        chk("abort_ready", 32'(bus.ready), 32'd1);
        chk("abort_drop", 32'(drop_cnt), 32'd0);
        bus.sram_rdata_vld = 1'b1;
        bus.sram_rdata     = 8'h77;
        tick();
        bus.sram_rdata_vld = 1'b0;
        chk("abort_late_rv", 32'(bus.rd_pxl_valid), 32'd0);
        tick();
        chk("abort_late_rv2", 32'(bus.rd_pxl_valid), 32'd0);
        chk("abort_late_req", 32'(bus.sram_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
